// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side bundle of the dual-clock FIFO: consumer requests, the write pointer
// arriving from the write domain, and all read-domain status outputs.
interface fifo_rd_ptr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   wr_ptr_gray;
    logic [ADDR_WIDTH:0]   rd_ptr_gray;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  underflow;

    // master: consumer / write-domain side; slave: the pointer controller
    modport master (
        output rd_en, wr_ptr_gray,
        input  rd_ptr_gray, rd_addr, rd_valid, empty, almost_empty, rd_count, underflow
    );

    modport slave (
        input  rd_en, wr_ptr_gray,
        output rd_ptr_gray, rd_addr, rd_valid, empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer controller: synchronizes the gray write pointer, advances the
// read pointer and derives empty / almost-empty / fill level / RAM read address.
module fifo_rd_ptr_ctrl #(
    parameter int ADDR_WIDTH          = 4,
    parameter int SYNC_STAGES         = 2,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_ptr_ctrl_if.slave    bus
);
    localparam int PW = ADDR_WIDTH + 1;

    genvar gi;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("fifo_rd_ptr_ctrl: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    // Raw flop chain: the first stage samples the foreign-domain pointer directly.
    (* ASYNC_REG = "TRUE" *) logic [PW-1:0] sync_reg [SYNC_STAGES];

    logic [PW-1:0] wr_gray_s;
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] rd_ptr_bin_reg;
    logic [PW-1:0] rd_ptr_gray_reg;
    logic          empty_reg;
    logic          almost_empty_reg;
    logic [PW-1:0] rd_count_reg;
    logic          rd_valid_reg;
    logic          underflow_reg;

    logic          rd_fire;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] fill_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= bus.wr_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign wr_gray_s = sync_reg[SYNC_STAGES-1];

    // Each binary bit is the XOR of all gray bits at and above it.
    generate
        for (gi = 0; gi < PW; gi++) begin : g_g2b
            assign wr_bin_s[gi] = ^wr_gray_s[PW-1:gi];
        end
    endgenerate

    assign rd_fire      = bus.rd_en & ~empty_reg;
    assign rd_bin_next  = rd_ptr_bin_reg + PW'(rd_fire);
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    assign fill_next    = wr_bin_s - rd_bin_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_bin_reg   <= '0;
            rd_ptr_gray_reg  <= '0;
            empty_reg        <= 1'b1;
            almost_empty_reg <= 1'b1;
            rd_count_reg     <= '0;
            rd_valid_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            rd_ptr_bin_reg   <= rd_bin_next;
            rd_ptr_gray_reg  <= rd_gray_next;
            empty_reg        <= (rd_gray_next == wr_gray_s);
            almost_empty_reg <= (fill_next <= PW'(ALMOST_EMPTY_THRESH));
            rd_count_reg     <= fill_next;
            rd_valid_reg     <= rd_fire;
            underflow_reg    <= bus.rd_en & empty_reg;
        end
    end

    // RAM samples rd_addr on the edge where rd_fire is high; data is valid one cycle later.
    assign bus.rd_addr      = rd_ptr_bin_reg[ADDR_WIDTH-1:0];
    assign bus.rd_ptr_gray  = rd_ptr_gray_reg;
    assign bus.rd_valid     = rd_valid_reg;
    assign bus.empty        = empty_reg;
    assign bus.almost_empty = almost_empty_reg;
    assign bus.rd_count     = rd_count_reg;
    assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed + random bench for fifo_rd_ptr_ctrl: a cycle model of the read side pushes
// expected outputs when stimulus is driven; they are popped and compared after the edge.
module tb_fifo_rd_ptr_ctrl;
    localparam int AW   = 4;
    localparam int PW   = AW + 1;
    localparam int SYNC = 2;
    localparam int AE   = 2;

    typedef struct packed {
        logic [PW-1:0] gray;
        logic [AW-1:0] addr;
        logic          valid;
        logic          empty;
        logic          almost;
        logic [PW-1:0] count;
        logic          uf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fifo_rd_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_rd_ptr_ctrl #(
        .ADDR_WIDTH(AW),
        .SYNC_STAGES(SYNC),
        .ALMOST_EMPTY_THRESH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    exp_t sb[$];

    // Reference model state: read pointer, registered empty, and the write pointer
    // (binary) as it travels through the synchronizer.
    logic [PW-1:0] m_rd;
    logic [PW-1:0] m_sync [SYNC];
    logic          m_empty;
    logic [PW-1:0] wbin;
    int            valid_cnt, uf_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input logic r, input logic en, input logic [PW-1:0] wb);
        exp_t e;
        logic          fire;
        logic [PW-1:0] nrd, cnt;
        rst             = r;
        bus.rd_en       = en;
        bus.wr_ptr_gray = wb ^ (wb >> 1);
        if (r) begin
            e = '{gray: '0, addr: '0, valid: 1'b0, empty: 1'b1, almost: 1'b1, count: '0, uf: 1'b0};
            m_rd    = '0;
            m_empty = 1'b1;
            for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        end else begin
            fire     = en & ~m_empty;
            nrd      = m_rd + PW'(fire);
            cnt      = m_sync[SYNC-1] - nrd;
            e.count  = cnt;
            e.empty  = (cnt == '0);
            e.almost = (int'(cnt) <= AE);
            e.valid  = fire;
            e.uf     = en & m_empty;
            e.gray   = nrd ^ (nrd >> 1);
            e.addr   = nrd[AW-1:0];
            m_rd     = nrd;
            m_empty  = e.empty;
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = wb;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        $display("cyc=%0d rst=%b rd_en=%b wr_gray=%b | addr=%0d cnt=%0d empty=%b ae=%b valid=%b uf=%b rd_gray=%b",
                 cyc, r, en, bus.wr_ptr_gray, bus.rd_addr, bus.rd_count, bus.empty,
                 bus.almost_empty, bus.rd_valid, bus.underflow, bus.rd_ptr_gray);
        chk("rd_ptr_gray",  32'(bus.rd_ptr_gray),  32'(e.gray));
        chk("rd_addr",      32'(bus.rd_addr),      32'(e.addr));
        chk("rd_valid",     32'(bus.rd_valid),     32'(e.valid));
        chk("empty",        32'(bus.empty),        32'(e.empty));
        chk("almost_empty", 32'(bus.almost_empty), 32'(e.almost));
        chk("rd_count",     32'(bus.rd_count),     32'(e.count));
        chk("underflow",    32'(bus.underflow),    32'(e.uf));
        valid_cnt += int'(bus.rd_valid);
        uf_cnt    += int'(bus.underflow);
    endtask

    initial begin
        rst = 1'b1;
        bus.rd_en = 1'b0;
        bus.wr_ptr_gray = '0;
        m_rd = '0;
        m_empty = 1'b1;
        for (int i = 0; i < SYNC; i++) m_sync[i] = '0;

        // Reset held with a nonzero write pointer (gray 00110 = binary 4)
        wbin = 5'd4;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, wbin);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_count", 32'(bus.rd_count), 32'd0);
        tick(1'b0, 1'b0, wbin);
        tick(1'b0, 1'b0, wbin);
        chk("empty_edge2", 32'(bus.empty), 32'd1);
        tick(1'b0, 1'b0, wbin);
        chk("empty_edge3", 32'(bus.empty), 32'd0);
        chk("count_edge3", 32'(bus.rd_count), 32'd4);

        // Write pointer stepping 0,1,2,3 (gray 0,1,3,2) with no reads
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 5'(i));
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 5'd3);
        chk("step_count", 32'(bus.rd_count), 32'd3);
        chk("step_almost", 32'(bus.almost_empty), 32'd0);

        // Four words available, six reads requested
        tick(1'b1, 1'b0, '0);
        wbin = 5'd4;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, wbin);
        valid_cnt = 0;
        uf_cnt = 0;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, wbin);
        tick(1'b0, 1'b0, wbin);
        chk("burst_valid_pulses", 32'(valid_cnt), 32'd4);
        chk("burst_underflows", 32'(uf_cnt), 32'd2);
        chk("burst_rd_gray", 32'(bus.rd_ptr_gray), 32'b00110);
        chk("burst_empty", 32'(bus.empty), 32'd1);

        // Pointer wrap 31->0 with continuous reads, writer kept ahead
        tick(1'b1, 1'b0, '0);
        wbin = 5'd6;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, wbin);
        for (int i = 0; i < 45; i++) begin
            wbin = wbin + 5'd1;
            tick(1'b0, 1'b1, wbin);
        end
        chk("wrap_rd_gray", 32'(bus.rd_ptr_gray), 32'(m_rd ^ (m_rd >> 1)));

        // Full: 16 words outstanding
        tick(1'b1, 1'b0, '0);
        wbin = 5'd16;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, wbin);
        chk("full_count", 32'(bus.rd_count), 32'd16);
        chk("full_almost", 32'(bus.almost_empty), 32'd0);

        // Reset in the middle of a read burst
        tick(1'b1, 1'b0, '0);
        wbin = 5'd7;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, wbin);
        chk("pre_reset_count", 32'(bus.rd_count), 32'd7);
        tick(1'b0, 1'b1, wbin);
        tick(1'b1, 1'b1, wbin);
        chk("midrst_gray", 32'(bus.rd_ptr_gray), 32'd0);
        chk("midrst_empty", 32'(bus.empty), 32'd1);
        chk("midrst_valid", 32'(bus.rd_valid), 32'd0);

        // Random traffic: writer advances at most one per cycle, never past full
        tick(1'b1, 1'b0, '0);
        wbin = '0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(1, 0) == 1 && (wbin - m_rd) < 5'd16) wbin = wbin + 5'd1;
            tick(1'b0, 1'($urandom_range(1, 0)), wbin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ptr_ctrl.md
Name: fifo_rd_ptr_ctrl

Overview:
Read-domain pointer controller for the dual-clock RAM FIFO. It consumes the write-side gray-coded pointer, which is produced in the write clock domain by the gray counter stage, and synchronizes it into the read clock. It keeps the read pointer in binary and gray form, and generates empty, almost-empty, fill-level, RAM read address and read-data-valid. Its registered gray read pointer returns to the write domain for full detection.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
SYNC_STAGES, 2, number of synchronizer flops on wr_ptr_gray; legal range 2..4.
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when rd_count <= this value.

Ports:
clk  input  1  read-domain clock.
rst  input  1  synchronous, active-high reset.
rd_en  input  1  read request from consumer.
wr_ptr_gray  input  ADDR_WIDTH+1  gray write pointer, asynchronous to clk.
rd_ptr_gray  output  ADDR_WIDTH+1  registered gray read pointer, sent to the write domain.
rd_addr  output  ADDR_WIDTH  RAM read address = rd_ptr_bin[ADDR_WIDTH-1:0].
rd_valid  output  1  RAM read data valid; one-cycle pulse.
empty  output  1  FIFO empty, registered.
almost_empty  output  1  rd_count <= ALMOST_EMPTY_THRESH, registered.
rd_count  output  ADDR_WIDTH+1  words available, registered, range 0..2**ADDR_WIDTH.
underflow  output  1  one-cycle pulse on rd_en while empty.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high, sampled on posedge clk only.
- Reset values:
  - All synchronizer flops, rd_ptr_bin and rd_ptr_gray = 0.
  - rd_addr = 0.
  - empty = 1, almost_empty = 1.
  - rd_count = 0, rd_valid = 0, underflow = 0.
- Reset mid-operation: on the next edge every state returns to its reset value regardless of rd_en or wr_ptr_gray. No partial pointer update.
- Synchronizer:
  - wr_ptr_gray passes through a SYNC_STAGES flop chain, producing wr_gray_s.
  - Apply no logic before the first flop.
  - Mark the flops for the ASYNC_REG attribute.
- Gray-to-binary: wr_bin_s[MSB] = wr_gray_s[MSB]; wr_bin_s[i] = wr_bin_s[i+1] ^ wr_gray_s[i]. This is combinational from wr_gray_s.
- Read fire: rd_fire = rd_en & ~empty. rd_en while empty is ignored for pointer movement.
- Next pointer: rd_bin_next = rd_ptr_bin + rd_fire, modulo 2**(ADDR_WIDTH+1). It wraps from all-ones to 0.
- Gray pointer: rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - rd_ptr_gray is a flop loaded with rd_gray_next. It changes at most one bit per cycle and has no combinational output path.
- Empty: empty <= (rd_gray_next == wr_gray_s).
- Fill level: rd_count <= wr_bin_s - rd_bin_next, computed at ADDR_WIDTH+1 bits modulo.
  - Value 2**ADDR_WIDTH (MSB set, rest 0) means full.
- almost_empty <= ((wr_bin_s - rd_bin_next) <= ALMOST_EMPTY_THRESH), using the same expression as rd_count.
- rd_addr and rd_valid:
  - rd_addr is the current rd_ptr_bin low bits.
  - The RAM samples rd_addr on the same edge that rd_fire is high.
  - rd_valid <= rd_fire, so it is high exactly the cycle after each accepted read.
- underflow <= rd_en & empty.
- Latency:
  - rd_fire to rd_ptr_gray/empty/rd_count update: 1 cycle.
  - wr_ptr_gray change to empty deassert: SYNC_STAGES+1 clk edges. This path is pessimistic: the FIFO may show empty while words exist, never the reverse.
- Simultaneous read and pointer advance: both contribute in the same cycle, for example count 3, one read, sync pointer +1 gives count 3.
- Back-to-back reads are allowed every cycle while ~empty. Reading the last word sets empty on the next edge, so a second rd_en in that cycle is an underflow.

Test Plan:
- Reset with wr_ptr_gray=5'b00110 held during rst -> all outputs at reset values while rst=1. After release: empty drops at edge 3 (SYNC_STAGES=2), rd_count=4.
- Write pointer steps gray 0->1->3->2 one per cycle, rd_en=0 -> rd_count follows 1,2,3 delayed by 3 edges; almost_empty deasserts when rd_count=3.
- wr_ptr_gray at binary 4, rd_en held high 6 cycles:
  - rd_addr steps 0,1,2,3.
  - rd_valid is high 4 cycles.
  - empty=1 after the 4th read.
  - underflow pulses for the remaining 2 cycles.
  - rd_ptr_gray=5'b00110.
- Wrap: drive pointers through 31->0 (gray 10000 -> 00000) with continuous reads -> rd_ptr_bin wraps 31->0, rd_count stays correct, no false empty or full.
- Full: wr_ptr_gray = gray(16), rd_ptr=0 -> rd_count=16 and almost_empty=0.
- Reset asserted mid-burst (rd_count=7, rd_en=1) -> next edge rd_ptr_gray=0, empty=1, rd_valid=0.
